// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the EX-stage RV32M multiply/divide unit.
// Also holds the operand magnitude helper used on operation entry.
package muldiv_pkg;

  localparam int unsigned ITERATIONS = 32;
  localparam logic [31:0] DIV0_Q     = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // funct3 encodings of the RV32M instructions
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } muldiv_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative radix-2 RV32M unit: shift-add multiply, restoring divide, 32 iterations each.
// Operands are held as magnitudes; the sign is applied once when the result is loaded.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic [63:0]   acc_q, acc_d;
  logic [32:0]   rem_q, rem_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic [31:0]   result_q, result_d;

  // Entry decode
  muldiv_op_e  op_in;
  logic        sign_a, sign_b, sa, sb, is_div, is_rem, div0, ovf, neg_in;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    op_in  = muldiv_op_e'(op);
    sign_a = op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    sign_b = op_in inside {OpMulh, OpDiv, OpRem};
    sa     = sign_a & a[31];
    sb     = sign_b & b[31];
    mag_a  = abs32(a, sign_a);
    mag_b  = abs32(b, sign_b);
    is_div = op[2];
    is_rem = op_in inside {OpRem, OpRemu};
    div0   = is_div && (b == 32'd0);
    ovf    = (op_in inside {OpDiv, OpRem}) && (a == INT_MIN) && (b == 32'hFFFF_FFFF);
    // Remainder follows the dividend's sign; product and quotient follow the XOR.
    neg_in = (op_in == OpRem) ? sa : (sa ^ sb);
  end

  // One iteration of each datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_next, prod_fix;
  logic [32:0] div_shift, div_diff, rem_next;
  logic        div_ge;
  logic [31:0] quo_next, quo_fix, rem_fix;
  logic        last;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    prod_fix  = neg_q ? (~mul_next + 64'd1) : mul_next;
    div_shift = {rem_q[31:0], opa_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = ~div_diff[32];
    rem_next  = div_ge ? div_diff : div_shift;
    quo_next  = {opa_q[30:0], div_ge};
    quo_fix   = neg_q ? (~quo_next + 32'd1) : quo_next;
    rem_fix   = neg_q ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];
    last      = (cnt_q == 6'(ITERATIONS - 1));
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (op_valid && !flush) begin
          op_d  = op_in;
          opa_d = mag_a;
          opb_d = mag_b;
          neg_d = neg_in;
          cnt_d = 6'd0;
          rem_d = 33'd0;
          acc_d = is_div ? 64'd0 : {32'd0, mag_b};
          if (div0) begin
            state_d  = StDone;
            result_d = is_rem ? a : DIV0_Q;
          end else if (ovf) begin
            state_d  = StDone;
            result_d = is_rem ? 32'd0 : INT_MIN;
          end else begin
            state_d = is_div ? StDiv : StMul;
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 6'd1;
        if (last) begin
          state_d  = StDone;
          result_d = (op_q == OpMul) ? prod_fix[31:0] : prod_fix[63:32];
        end
      end
      StDiv: begin
        rem_d = rem_next;
        opa_d = quo_next;
        cnt_d = cnt_q + 6'd1;
        if (last) begin
          state_d  = StDone;
          result_d = (op_q inside {OpRem, OpRemu}) ? rem_fix : quo_fix;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 6'd0;
      end
    endcase

    // Abort wins over acceptance and completion; the held result is untouched.
    if (flush) begin
      state_d  = StIdle;
      cnt_d    = 6'd0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      acc_q    <= 64'd0;
      rem_q    <= 33'd0;
      cnt_q    <= 6'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign done   = (state_q == StDone);
  assign stall  = op_valid & ~done;
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, stall, signed fix-up, special cases,
// flush, mid-operation reset and back-to-back issue.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        stall, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .op_valid (op_valid),
    .op       (op),
    .a        (a),
    .b        (b),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  // Issues one op in cycle N, scrambles the inputs after acceptance and measures
  // the cycle offset of done. lat = -1 if done never arrives within the budget.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] res, output int stall_bad,
                        output logic stall_at_done, output int n_start);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    n_start   = cyc;
    lat       = -1;
    stall_bad = 0;
    for (int k = 0; k < 80; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (stall !== 1'b1) stall_bad++;
      @(posedge clk); #1;
      a = $urandom; b = $urandom; op = 3'($urandom);
      @(negedge clk);
    end
    res           = result;
    stall_at_done = stall;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; op_valid = 1'b1; op = 3'd0; a = 32'd0; b = 32'd0;
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_hi: got %b want 1", stall); end
    op_valid = 1'b0; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall_lo: got %b want 0", stall); end
    @(posedge clk); #1; rst = 1'b1;
    idle_cycle();
  endtask

  task automatic test_mul();
    int lat, sb, n; logic [31:0] r; logic sd;
    run_op(3'd0, 32'd7, 32'd6, lat, r, sb, sd, n);
    total++; if (lat !== 33) begin bad++; $display("FAIL mul_lat: got %0d want 33", lat); end
    total++; if (r !== 32'h2A) begin bad++; $display("FAIL mul_res: got %h want 0000002a", r); end
    total++; if (sb !== 0) begin bad++; $display("FAIL mul_stall: %0d cycles low, want 0", sb); end
    total++; if (sd !== 1'b0) begin bad++; $display("FAIL mul_stall_done: got %b want 0", sd); end
    idle_cycle();
    run_op(3'd0, 32'hFFFF_FFFF, 32'd3, lat, r, sb, sd, n);
    total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL mul_neg: got %h want fffffffd", r); end
    idle_cycle();
  endtask

  task automatic test_mulh();
    int lat, sb, n; logic [31:0] r; logic sd;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, r, sb, sd, n);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL mulh: got %h want 00000000", r); end
    idle_cycle();
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, r, sb, sd, n);
    total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulhu: got %h want fffffffe", r); end
    idle_cycle();
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, lat, r, sb, sd, n);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulhsu: got %h want ffffffff", r); end
    total++; if (lat !== 33) begin bad++; $display("FAIL mulhsu_lat: got %0d want 33", lat); end
    idle_cycle();
  endtask

  task automatic test_div();
    int lat, sb, n; logic [31:0] r; logic sd;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, lat, r, sb, sd, n);
    total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div: got %h want fffffffd", r); end
    total++; if (lat !== 33) begin bad++; $display("FAIL div_lat: got %0d want 33", lat); end
    total++; if (sb !== 0) begin bad++; $display("FAIL div_stall: %0d cycles low, want 0", sb); end
    idle_cycle();
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, lat, r, sb, sd, n);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem: got %h want ffffffff", r); end
    idle_cycle();
    run_op(3'd5, 32'd100, 32'd7, lat, r, sb, sd, n);
    total++; if (r !== 32'd14) begin bad++; $display("FAIL divu: got %h want 0000000e", r); end
    idle_cycle();
    run_op(3'd7, 32'd100, 32'd7, lat, r, sb, sd, n);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL remu: got %h want 00000002", r); end
    idle_cycle();
  endtask

  task automatic test_special();
    int lat, sb, n; logic [31:0] r; logic sd;
    run_op(3'd5, 32'd5, 32'd0, lat, r, sb, sd, n);
    total++; if (lat !== 1) begin bad++; $display("FAIL div0_lat: got %0d want 1", lat); end
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_res: got %h want ffffffff", r); end
    idle_cycle();
    run_op(3'd6, 32'd9, 32'd0, lat, r, sb, sd, n);
    total++; if (r !== 32'd9) begin bad++; $display("FAIL rem0_res: got %h want 00000009", r); end
    idle_cycle();
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, sb, sd, n);
    total++; if (lat !== 1) begin bad++; $display("FAIL ovf_lat: got %0d want 1", lat); end
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL ovf_div: got %h want 80000000", r); end
    idle_cycle();
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, sb, sd, n);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL ovf_rem: got %h want 00000000", r); end
    idle_cycle();
  endtask

  task automatic test_flush();
    int lat, sb, n, seen; logic [31:0] r; logic sd;
    @(posedge clk); #1;
    op_valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
    seen = 0;
    repeat (10) begin
      @(negedge clk); if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk); if (done === 1'b1) seen++;
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk); if (done === 1'b1) seen++;
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_done: %0d pulses want 0", seen); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall); end
    run_op(3'd0, 32'd3, 32'd3, lat, r, sb, sd, n);
    total++; if (lat !== 33) begin bad++; $display("FAIL flush_mul_lat: got %0d want 33", lat); end
    total++; if (r !== 32'd9) begin bad++; $display("FAIL flush_mul_res: got %h want 00000009", r); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, sb, n1, n2, seen; logic [31:0] r1, r2; logic sd;
    @(posedge clk); #1;
    op_valid = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0; #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL rstmid_result: got %h want 0", result); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rstmid_stall: got %b want 1", stall); end
    @(posedge clk); #1; op_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_nodone: %0d pulses want 0", seen); end
    run_op(3'd0, 32'h0001_2345, 32'h10, lat1, r1, sb, sd, n1);
    run_op(3'd5, 32'd1000, 32'd33, lat2, r2, sb, sd, n2);
    total++; if (lat1 !== 33) begin bad++; $display("FAIL b2b_lat1: got %0d want 33", lat1); end
    total++; if ((n2 + lat2 - n1) !== 67) begin
      bad++; $display("FAIL b2b_lat2: got %0d want 67", n2 + lat2 - n1);
    end
    total++; if (r1 !== 32'h0012_3450) begin bad++; $display("FAIL b2b_mul: got %h want 00123450", r1); end
    total++; if (r2 !== 32'd30) begin bad++; $display("FAIL b2b_divu: got %h want 0000001e", r2); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
